// File: rtl/bpsk_pkg.sv
// Shared widths, decoding-mode encodings and sizing helper for the BPSK correlator.
package bpsk_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SPS        = 16;
  localparam int DEF_ACC_WIDTH  = 2*DEF_DATA_WIDTH + 16;

  typedef enum int {
    DIFF_COHERENT = 0,
    DIFF_DBPSK    = 1
  } diff_mode_e;

  // Narrowest accumulator that cannot overflow over one full symbol.
  function automatic int min_acc_width(int dw, int sps);
    return 2*dw + $clog2(sps);
  endfunction
endpackage

// File: rtl/bpsk_correlator_if.sv
// Sample stream in, symbol decisions out; slave is the correlator's view.
interface bpsk_correlator_if import bpsk_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
);
  logic signed [DATA_WIDTH-1:0] signal;
  logic                         sample_valid;
  logic                         symbol_sync;
  logic                         sym_valid;
  logic                         sym_ready;
  logic                         sym_bit;
  logic                         sym_erasure;
  logic signed [ACC_WIDTH-1:0]  sym_metric;
  logic                         overrun;
  logic                         clear_overrun;

  modport slave (
    input  signal, sample_valid, symbol_sync, sym_ready, clear_overrun,
    output sym_valid, sym_bit, sym_erasure, sym_metric, overrun
  );
  modport master (
    output signal, sample_valid, symbol_sync, sym_ready, clear_overrun,
    input  sym_valid, sym_bit, sym_erasure, sym_metric, overrun
  );
endinterface

// File: rtl/sine_wave.sv
// One-period sine ROM over SAMPLES_PER_SYMBOL phases, built at elaboration from
// the integer Bhaskara approximation (no real arithmetic in hardware).
module sine_wave import bpsk_pkg::*; #(
  parameter  int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter  int SAMPLES_PER_SYMBOL = DEF_SPS,
  localparam int PW                 = $clog2(SAMPLES_PER_SYMBOL)
) (
  input  logic [PW-1:0]                i_phase,
  output logic signed [DATA_WIDTH-1:0] o_amp
);
  function automatic logic signed [DATA_WIDTH-1:0] sine_at(int k);
    longint n, amp, x, q, mag;
    bit     neg;
    n   = SAMPLES_PER_SYMBOL;
    amp = (64'sd1 <<< (DATA_WIDTH-1)) - 1;
    x   = 2*longint'(k);
    neg = (x >= n);
    if (neg) x = x - n;
    // x/n is the position within the half period; 16q/(5n^2-4q) ~ sin
    q   = x * (n - x);
    mag = (amp * 16 * q) / (5*n*n - 4*q);
    return DATA_WIDTH'(neg ? -mag : mag);
  endfunction

  logic signed [DATA_WIDTH-1:0] w_tab [SAMPLES_PER_SYMBOL];

  for (genvar k = 0; k < SAMPLES_PER_SYMBOL; k++) begin : g_tab
    assign w_tab[k] = sine_at(k);
  end

  assign o_amp = w_tab[i_phase];
endmodule

// File: rtl/bpsk_correlator.sv
// Sine-reference correlator: integrates signal*ref over each symbol, decides the
// bit (coherent or differential) and holds it behind a valid/ready register.
module bpsk_correlator import bpsk_pkg::*; #(
  parameter int          DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int          SAMPLES_PER_SYMBOL = DEF_SPS,
  parameter int          ACC_WIDTH          = 2*DATA_WIDTH + 16,
  parameter int unsigned ERASE_THRESH       = 0,
  parameter int          DIFF_MODE          = DIFF_COHERENT
) (
  input logic                clock,
  input logic                reset_n,
  bpsk_correlator_if.slave   bus
);
  localparam int            PW     = $clog2(SAMPLES_PER_SYMBOL);
  localparam int            PROD_W = 2*DATA_WIDTH;
  localparam logic [PW-1:0] LAST   = PW'(SAMPLES_PER_SYMBOL - 1);

  if (ACC_WIDTH < min_acc_width(DATA_WIDTH, SAMPLES_PER_SYMBOL)) begin : g_acc_chk
    $fatal(1, "bpsk_correlator: ACC_WIDTH too narrow for DATA_WIDTH/SAMPLES_PER_SYMBOL");
  end
  if (SAMPLES_PER_SYMBOL < 2 || SAMPLES_PER_SYMBOL > 65535) begin : g_sps_chk
    $fatal(1, "bpsk_correlator: SAMPLES_PER_SYMBOL out of range 2..65535");
  end

  logic [PW-1:0]                r_phase, w_phase;
  logic signed [ACC_WIDTH-1:0]  r_acc, w_base, w_prod_ext, w_sum, r_metric;
  logic signed [DATA_WIDTH-1:0] w_ref;
  logic signed [PROD_W-1:0]     w_prod;
  logic [ACC_WIDTH-1:0]         w_mag;
  logic                         w_last, w_raw, w_bit, w_erase;
  logic                         r_prev_raw, r_sym_valid, r_bit, r_erase, r_overrun;

  // A sync pulse makes this cycle's sample phase 0 of a fresh symbol.
  assign w_phase = bus.symbol_sync ? '0 : r_phase;
  assign w_base  = bus.symbol_sync ? '0 : r_acc;

  sine_wave #(
    .DATA_WIDTH        (DATA_WIDTH),
    .SAMPLES_PER_SYMBOL(SAMPLES_PER_SYMBOL)
  ) u_sine (
    .i_phase(w_phase),
    .o_amp  (w_ref)
  );

  assign w_prod     = bus.signal * w_ref;
  assign w_prod_ext = {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_sum      = w_base + w_prod_ext;
  assign w_last     = bus.sample_valid && (w_phase == LAST);

  assign w_raw   = w_sum[ACC_WIDTH-1];
  assign w_bit   = (DIFF_MODE == DIFF_DBPSK) ? (w_raw ^ r_prev_raw) : w_raw;
  assign w_mag   = w_raw ? -w_sum : w_sum;
  assign w_erase = {1'b0, w_mag} < (ACC_WIDTH+1)'(ERASE_THRESH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase    <= '0;
      r_acc      <= '0;
      r_prev_raw <= 1'b0;
    end else begin
      if (bus.sample_valid) begin
        r_phase <= w_last ? '0 : w_phase + 1'b1;
        r_acc   <= w_last ? '0 : w_sum;
      end else if (bus.symbol_sync) begin
        r_phase <= '0;
        r_acc   <= '0;
      end
      if (bus.symbol_sync)  r_prev_raw <= 1'b0;
      else if (w_last)      r_prev_raw <= w_raw;
    end
  end

  // Decision register: a new decision always loads, even over an unconsumed one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sym_valid <= 1'b0;
      r_bit       <= 1'b0;
      r_erase     <= 1'b0;
      r_metric    <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_last) begin
        r_sym_valid <= 1'b1;
        r_bit       <= w_bit;
        r_erase     <= w_erase;
        r_metric    <= w_sum;
      end else if (r_sym_valid && bus.sym_ready) begin
        r_sym_valid <= 1'b0;
      end
      if (w_last && r_sym_valid && !bus.sym_ready) r_overrun <= 1'b1;
      else if (bus.clear_overrun)                  r_overrun <= 1'b0;
    end
  end

  assign bus.sym_valid   = r_sym_valid;
  assign bus.sym_bit     = r_bit;
  assign bus.sym_erasure = r_erase;
  assign bus.sym_metric  = r_metric;
  assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_bpsk_correlator.sv
// Scoreboard bench: a coherent and a differential correlator share one stimulus
// stream; a symbol-level reference model queues expected decisions.
module tb_bpsk_correlator;
  import bpsk_pkg::*;

  localparam int N    = 16;
  localparam int TH_C = 20000;

  typedef struct {
    longint sum;
    bit     bc, ec, bd, ed;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic signed [7:0] tb_sig = '0;
  logic tb_vld = 1'b0, tb_sync = 1'b0, tb_rdy = 1'b0, tb_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q[$];
  int   samp[$];
  bit   prev_d = 1'b0;
  bit   m_valid = 1'b0;
  bit   m_ov = 1'b0;

  always #5 clock = ~clock;

  bpsk_correlator_if #(.DATA_WIDTH(8), .ACC_WIDTH(32)) bus_c();
  bpsk_correlator_if #(.DATA_WIDTH(8), .ACC_WIDTH(32)) bus_d();

  assign bus_c.signal = tb_sig;  assign bus_d.signal = tb_sig;
  assign bus_c.sample_valid = tb_vld;  assign bus_d.sample_valid = tb_vld;
  assign bus_c.symbol_sync = tb_sync;  assign bus_d.symbol_sync = tb_sync;
  assign bus_c.sym_ready = tb_rdy;  assign bus_d.sym_ready = tb_rdy;
  assign bus_c.clear_overrun = tb_clr;  assign bus_d.clear_overrun = tb_clr;

  bpsk_correlator #(.DATA_WIDTH(8), .SAMPLES_PER_SYMBOL(N), .ACC_WIDTH(32),
                    .ERASE_THRESH(TH_C), .DIFF_MODE(0))
    dut_c (.clock(clock), .reset_n(reset_n), .bus(bus_c));
  bpsk_correlator #(.DATA_WIDTH(8), .SAMPLES_PER_SYMBOL(N), .ACC_WIDTH(32),
                    .ERASE_THRESH(1), .DIFF_MODE(1))
    dut_d (.clock(clock), .reset_n(reset_n), .bus(bus_d));

  task automatic chk(string name, longint act, longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference amplitude: 127 * sin(2*pi*k/N) via Bhaskara's rational form.
  function automatic longint ref_amp(int k);
    longint n, x, q2, m;
    bit neg;
    n = N; x = 2*k; neg = (x >= n);
    if (neg) x -= n;
    q2 = x * (n - x);
    m  = (127 * 16 * q2) / (5*n*n - 4*q2);
    return neg ? -m : m;
  endfunction

  // Drive one cycle starting just after a rising edge; model the coming edge.
  task automatic step(bit v, int s, bit sy, bit rdy, bit clr);
    exp_t e;
    bit decide = 0, nv, nov, set = 0;
    longint mag;
    tb_vld = v; tb_sig = 8'(s); tb_sync = sy; tb_rdy = rdy; tb_clr = clr;
    if (sy) begin samp.delete(); prev_d = 0; end
    if (v) begin
      samp.push_back(s);
      if (samp.size() == N) begin
        e.sum = 0;
        foreach (samp[k]) e.sum += longint'(samp[k]) * ref_amp(k);
        e.bc = (e.sum < 0);
        e.bd = e.bc ^ prev_d;
        prev_d = e.bc;
        mag = (e.sum < 0) ? -e.sum : e.sum;
        e.ec = (mag < TH_C);
        e.ed = (mag < 1);
        samp.delete();
        decide = 1;
      end
    end
    nv = m_valid;
    if (decide) begin
      if (m_valid && !rdy) begin void'(q.pop_back()); set = 1; end
      q.push_back(e);
      nv = 1;
    end else if (m_valid && rdy) nv = 0;
    nov = set ? 1'b1 : (clr ? 1'b0 : m_ov);
    @(posedge clock); #1;
    m_valid = nv; m_ov = nov;
  endtask

  task automatic do_reset();
    tb_vld = 0; tb_sync = 0; tb_rdy = 0; tb_clr = 0; tb_sig = '0;
    reset_n = 0;
    samp.delete(); q.delete(); prev_d = 0; m_valid = 0; m_ov = 0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1;
  endtask

  // kind: 0 = +ref, 1 = -ref, 2 = zeros, 3 = random
  task automatic send_symbol(int kind, bit rdy, bit clr_last, bit half);
    int s;
    for (int k = 0; k < N; k++) begin
      case (kind)
        0: s = int'(ref_amp(k));
        1: s = -int'(ref_amp(k));
        2: s = 0;
        default: s = int'($urandom_range(0, 254)) - 127;
      endcase
      if (half) step(0, 0, 0, rdy, 0);
      step(1, s, 0, rdy, clr_last && (k == N-1));
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    chk("sym_valid_c", bus_c.sym_valid, m_valid);
    chk("sym_valid_d", bus_d.sym_valid, m_valid);
    chk("overrun_c", bus_c.overrun, m_ov);
    chk("overrun_d", bus_d.overrun, m_ov);
    if (bus_c.sym_valid && tb_rdy) begin
      if (q.size() == 0) chk("scoreboard_underflow", 1, 0);
      else begin
        e = q.pop_front();
        chk("metric_c", longint'(bus_c.sym_metric), e.sum);
        chk("metric_d", longint'(bus_d.sym_metric), e.sum);
        chk("bit_c", bus_c.sym_bit, e.bc);
        chk("bit_d", bus_d.sym_bit, e.bd);
        chk("erasure_c", bus_c.sym_erasure, e.ec);
        chk("erasure_d", bus_d.sym_erasure, e.ed);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset_n = 1;
    chk("rst_bit", bus_c.sym_bit, 0);
    chk("rst_erasure", bus_c.sym_erasure, 0);
    chk("rst_metric", longint'(bus_c.sym_metric), 0);
    chk("rst_metric_d", longint'(bus_d.sym_metric), 0);

    // matched reference, then alternating symbols for the differential path
    send_symbol(0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) send_symbol(i % 2, 1, 0, 0);
    send_symbol(2, 1, 0, 0);

    // two decisions while stalled, then clear; then set and clear together
    send_symbol(3, 0, 0, 0);
    send_symbol(3, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    send_symbol(3, 0, 0, 0);
    send_symbol(3, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);

    // 50% sample_valid duty
    send_symbol(0, 1, 0, 1);

    // sync at phase 7, reset at phase 5, then a clean symbol
    for (int k = 0; k < 7; k++) step(1, int'(ref_amp(k)), 0, 1, 0);
    step(1, 40, 1, 1, 0);
    for (int k = 1; k < 5; k++) step(1, -50, 0, 1, 0);
    do_reset();
    send_symbol(0, 1, 0, 0);
    send_symbol(1, 1, 0, 0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 254)) - 127,
           $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 19) == 0);

    repeat (3) step(0, 0, 0, 1, 0);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bpsk_correlator.md
BPSK_CORRELATOR -- requirements
Module: bpsk_correlator

Interface
REQ-001 Parameter DATA_WIDTH, default 8: signed sample and reference-amplitude width.
REQ-002 Parameter SAMPLES_PER_SYMBOL, default 16: accepted samples per symbol (legal range 2..65535).
REQ-003 Parameter ACC_WIDTH, default 2*DATA_WIDTH+16: signed correlation accumulator width.
REQ-004 Parameter ERASE_THRESH, default 0: unsigned magnitude below which a decision is flagged as an erasure.
REQ-005 Parameter DIFF_MODE, default 0: 0 = coherent BPSK, 1 = differential (DBPSK) decoding.
REQ-006 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-007 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 Port signal, input, DATA_WIDTH: signed received sample.
REQ-009 Port sample_valid, input, 1: signal is accepted on this cycle; no input backpressure.
REQ-010 Port symbol_sync, input, 1: single-cycle pulse realigning the symbol boundary.
REQ-011 Port sym_valid, output, 1: decision register holds an unconsumed symbol.
REQ-012 Port sym_ready, input, 1: consumer accepts the symbol when sym_valid && sym_ready.
REQ-013 Port sym_bit, output, 1: decided bit.
REQ-014 Port sym_erasure, output, 1: |metric| < ERASE_THRESH for this symbol.
REQ-015 Port sym_metric, output, ACC_WIDTH: signed final correlation sum of this symbol.
REQ-016 Port overrun, output, 1: sticky; a held symbol was overwritten before being consumed.
REQ-017 Port clear_overrun, input, 1: synchronous clear of overrun.

Function
REQ-018 A phase counter of width clog2(SAMPLES_PER_SYMBOL) SHALL advance by 1 per accepted sample, wrapping from SAMPLES_PER_SYMBOL-1 to 0; it SHALL hold when sample_valid is low.
REQ-019 The reference amplitude SHALL be the signed DATA_WIDTH sine value indexed by the current phase, combinational, one full period per symbol.
REQ-020 Each accepted sample SHALL add the full-precision product signal*reference (2*DATA_WIDTH bits, sign-extended) to the accumulator; no sample SHALL be skipped at the boundary.
REQ-021 On the sample accepted at phase SAMPLES_PER_SYMBOL-1, the final sum (accumulator + that product) SHALL be decided and the accumulator SHALL load 0 on the same edge.
REQ-022 Coherent decision: raw bit = 1 if final sum < 0, else 0 (zero decides 0).
REQ-023 In DIFF_MODE=1, sym_bit SHALL be raw bit XOR previous raw bit; the previous raw bit is 0 after reset or symbol_sync.
REQ-024 Decision outputs (sym_bit, sym_erasure, sym_metric, sym_valid=1) SHALL be registered and visible exactly one cycle after the final sample is accepted.
REQ-025 sym_valid SHALL clear on the edge where sym_valid && sym_ready, unless a new decision loads on that same edge, in which case sym_valid stays 1 with the new data and overrun is not set.
REQ-026 If a new decision loads while sym_valid=1 and sym_ready=0, the outputs SHALL be overwritten and overrun SHALL set.
REQ-027 clear_overrun SHALL clear overrun; a simultaneous set SHALL win.
REQ-028 symbol_sync SHALL zero the phase and accumulator; if sample_valid is high on the same cycle, that sample SHALL be accumulated as phase 0 (reference index 0); a pending sym_valid SHALL be unaffected.
REQ-029 Outputs SHALL be stable while sym_valid=1 and no new decision loads.

Reset
REQ-030 On reset_n low: phase=0, accumulator=0, previous raw bit=0, sym_valid=0, sym_bit=0, sym_erasure=0, sym_metric=0, overrun=0; reset assertion mid-symbol SHALL discard the partial sum with no output.

Structure
REQ-031 A shared package bpsk_pkg SHALL hold the default widths, the DIFF_MODE encodings and a function computing the minimum safe ACC_WIDTH.
REQ-032 The existing sine_wave lookup SHALL be instantiated as the single sub-module for the reference amplitude.
REQ-033 An elaboration-time check SHALL fail if ACC_WIDTH < 2*DATA_WIDTH + clog2(SAMPLES_PER_SYMBOL).

Verification
REQ-034 16 samples equal to +reference, sample_valid continuous, sym_ready=1 -> one sym_valid pulse, cycle 17, sym_bit=0, sym_metric = sum of ref^2 (>0).
REQ-035 Alternating symbols +ref/-ref, DIFF_MODE=1 -> raw bits 0,1,0,1, sym_bit 0,1,1,1.
REQ-036 All-zero samples with ERASE_THRESH=1 -> sym_bit=0, sym_metric=0, sym_erasure=1.
REQ-037 sym_ready=0 across two symbol decisions -> second symbol's data on outputs, overrun=1; clear_overrun pulse -> overrun=0.
REQ-038 sample_valid toggling 50% -> decision after 16 accepted samples (about 32 cycles), metric identical to continuous case.
REQ-039 symbol_sync at phase 7, then reset_n low at phase 5 -> no decision emitted from either truncated symbol; next full symbol decides correctly.
